// File: rtl/cycle_event_counter_bank.sv
// Bank of NUM_CH event counters with shared run/halt control, atomic snapshot
// and sticky per-channel overflow flags (wrap or saturate on overflow).
//
// state | meaning
// ARM   | first cycle after reset; no counting; advances to RUN (or HALT on stop)
// RUN   | counting enabled
// HALT  | counts frozen until start
module cycle_event_counter_bank #(
    parameter int WIDTH      = 32,
    parameter int NUM_CH     = 4,
    parameter int SATURATE   = 0,
    parameter int CH0_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    clear_i,
    input  logic                    snap_i,
    input  logic [NUM_CH-1:0]       ev_i,
    output logic [NUM_CH*WIDTH-1:0] count_o,
    output logic [NUM_CH*WIDTH-1:0] snap_o,
    output logic                    snap_vld_o,
    output logic [NUM_CH-1:0]       ovf_o,
    output logic                    running_o
);

    typedef enum logic [1:0] {ST_ARM, ST_RUN, ST_HALT} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t                          state_q, state_d;
    logic                            running_q, running_d;
    logic [NUM_CH-1:0][WIDTH-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0][WIDTH-1:0]    snap_q, snap_d;
    logic                            snap_vld_q, snap_vld_d;
    logic [NUM_CH-1:0]               ovf_q, ovf_d;
    logic [NUM_CH-1:0]               ev_eff;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:  state_d = stop_i ? ST_HALT : ST_RUN;
            ST_RUN:  if (stop_i) state_d = ST_HALT;
            ST_HALT: if (!stop_i && start_i && !clear_i) state_d = ST_RUN;
            default: state_d = ST_ARM;
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_comb begin
        ev_eff = ev_i;
        if (CH0_CYCLES != 0) ev_eff[0] = 1'b1;
    end

    // Clear wins over any increment due in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = '0;
        end else if (state_q == ST_RUN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ev_eff[c]) begin
                    if (&cnt_q[c]) begin
                        ovf_d[c] = 1'b1;
                        if (SATURATE == 0) cnt_d[c] = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        snap_d     = snap_i ? cnt_q : snap_q;
        snap_vld_d = snap_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARM;
            running_q  <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            snap_vld_q <= snap_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign count_o    = cnt_q;
    assign snap_o     = snap_q;
    assign snap_vld_o = snap_vld_q;
    assign ovf_o      = ovf_q;
    assign running_o  = running_q;

endmodule

// File: tb/tb_cycle_event_counter_bank.sv
// Directed bench: one 32-bit bank plus 4-bit wrap and saturate banks on shared stimulus.
module tb_cycle_event_counter_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, snap_i = 1'b0;
    logic [3:0]  ev_i = 4'b0;

    logic [127:0] m_count, m_snap;
    logic         m_snap_vld, m_running;
    logic [3:0]   m_ovf;
    logic [15:0]  w_count, w_snap, s_count, s_snap;
    logic         w_snap_vld, w_running, s_snap_vld, s_running;
    logic [3:0]   w_ovf, s_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cycle_event_counter_bank #(.WIDTH(32), .NUM_CH(4), .SATURATE(0), .CH0_CYCLES(1)) u_main (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
        .snap_i(snap_i), .ev_i(ev_i), .count_o(m_count), .snap_o(m_snap),
        .snap_vld_o(m_snap_vld), .ovf_o(m_ovf), .running_o(m_running));

    cycle_event_counter_bank #(.WIDTH(4), .NUM_CH(4), .SATURATE(0), .CH0_CYCLES(1)) u_wrap (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
        .snap_i(snap_i), .ev_i(ev_i), .count_o(w_count), .snap_o(w_snap),
        .snap_vld_o(w_snap_vld), .ovf_o(w_ovf), .running_o(w_running));

    cycle_event_counter_bank #(.WIDTH(4), .NUM_CH(4), .SATURATE(1), .CH0_CYCLES(1)) u_sat (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
        .snap_i(snap_i), .ev_i(ev_i), .count_o(s_count), .snap_o(s_snap),
        .snap_vld_o(s_snap_vld), .ovf_o(s_ovf), .running_o(s_running));

    function automatic logic [31:0] ch32(input logic [127:0] v, input int c);
        return v[c*32 +: 32];
    endfunction

    function automatic logic [3:0] ch4(input logic [15:0] v, input int c);
        return v[c*4 +: 4];
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (m_count !== 128'd0 || m_snap !== 128'd0 || m_ovf !== 4'd0 ||
            m_running !== 1'b0 || m_snap_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs count=%h snap=%h ovf=%b run=%b vld=%b required all zero",
                     m_count, m_snap, m_ovf, m_running, m_snap_vld);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_autostart();
        step(1);
        checks++;
        if (m_running !== 1'b1 || ch32(m_count, 0) !== 32'd0) begin
            failures++;
            $display("FAIL autostart_edge1 running=%b ch0=%0d required running=1 ch0=0",
                     m_running, ch32(m_count, 0));
        end
        step(9);
        checks++;
        if (ch32(m_count, 0) !== 32'd9) begin
            failures++;
            $display("FAIL autostart_ch0 got=%0d required=9", ch32(m_count, 0));
        end
        checks++;
        if (m_count[127:32] !== 96'd0) begin
            failures++;
            $display("FAIL autostart_others got=%h required=0", m_count[127:32]);
        end
    endtask

    task automatic test_stop_hold();
        ev_i = 4'b0010;
        step(5);
        ev_i = 4'b0000;
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
        checks++;
        if (m_running !== 1'b0 || ch32(m_count, 1) !== 32'd5) begin
            failures++;
            $display("FAIL stop_edge running=%b ch1=%0d required running=0 ch1=5",
                     m_running, ch32(m_count, 1));
        end
        ev_i = 4'b0010;
        step(3);
        checks++;
        if (ch32(m_count, 1) !== 32'd5 || ch32(m_count, 0) !== 32'd15) begin
            failures++;
            $display("FAIL halt_hold ch1=%0d ch0=%0d required ch1=5 ch0=15",
                     ch32(m_count, 1), ch32(m_count, 0));
        end
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        checks++;
        if (m_running !== 1'b1 || ch32(m_count, 1) !== 32'd5 || ch32(m_count, 0) !== 32'd15) begin
            failures++;
            $display("FAIL restart_edge running=%b ch1=%0d ch0=%0d required running=1 ch1=5 ch0=15",
                     m_running, ch32(m_count, 1), ch32(m_count, 0));
        end
        step(1);
        checks++;
        if (ch32(m_count, 1) !== 32'd6) begin
            failures++;
            $display("FAIL restart_first_inc ch1=%0d required=6", ch32(m_count, 1));
        end
    endtask

    task automatic test_snap_clear();
        step(1);
        ev_i = 4'b0010;
        snap_i = 1'b1;
        clear_i = 1'b1;
        step(1);
        snap_i = 1'b0;
        clear_i = 1'b0;
        ev_i = 4'b0000;
        checks++;
        if (ch32(m_snap, 1) !== 32'd7 || ch32(m_snap, 0) !== 32'd17) begin
            failures++;
            $display("FAIL snap_values snap_ch1=%0d snap_ch0=%0d required 7 and 17",
                     ch32(m_snap, 1), ch32(m_snap, 0));
        end
        checks++;
        if (m_count !== 128'd0 || m_ovf !== 4'd0 || m_snap_vld !== 1'b1 || m_running !== 1'b1) begin
            failures++;
            $display("FAIL clear_result count=%h ovf=%b vld=%b run=%b required count=0 ovf=0 vld=1 run=1",
                     m_count, m_ovf, m_snap_vld, m_running);
        end
        step(1);
        checks++;
        if (m_snap_vld !== 1'b0 || ch32(m_count, 0) !== 32'd1 || ch32(m_snap, 1) !== 32'd7) begin
            failures++;
            $display("FAIL snap_after vld=%b ch0=%0d snap_ch1=%0d required vld=0 ch0=1 snap_ch1=7",
                     m_snap_vld, ch32(m_count, 0), ch32(m_snap, 1));
        end
    endtask

    task automatic test_all_controls();
        start_i = 1'b1;
        stop_i = 1'b1;
        clear_i = 1'b1;
        ev_i = 4'b1111;
        step(1);
        start_i = 1'b0;
        stop_i = 1'b0;
        clear_i = 1'b0;
        checks++;
        if (m_running !== 1'b0 || m_count !== 128'd0) begin
            failures++;
            $display("FAIL all_controls running=%b count=%h required running=0 count=0",
                     m_running, m_count);
        end
        step(2);
        ev_i = 4'b0000;
        checks++;
        if (m_count !== 128'd0) begin
            failures++;
            $display("FAIL all_controls_hold count=%h required=0", m_count);
        end
    endtask

    task automatic test_rst_midcount();
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(50);
        checks++;
        if (ch32(m_count, 0) !== 32'd50) begin
            failures++;
            $display("FAIL pre_rst_ch0 got=%0d required=50", ch32(m_count, 0));
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_count !== 128'd0 || m_snap !== 128'd0 || m_running !== 1'b0 ||
            m_ovf !== 4'd0 || m_snap_vld !== 1'b0) begin
            failures++;
            $display("FAIL async_rst count=%h snap=%h run=%b ovf=%b vld=%b required all zero",
                     m_count, m_snap, m_running, m_ovf, m_snap_vld);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1);
        checks++;
        if (m_running !== 1'b1 || ch32(m_count, 0) !== 32'd0) begin
            failures++;
            $display("FAIL post_rst_arm running=%b ch0=%0d required running=1 ch0=0",
                     m_running, ch32(m_count, 0));
        end
    endtask

    task automatic test_overflow();
        ev_i = 4'b0100;
        step(15);
        checks++;
        if (ch4(w_count, 2) !== 4'd15 || w_ovf[2] !== 1'b0 || ch4(s_count, 2) !== 4'd15 || s_ovf[2] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_boundary wrap=%0d/%b sat=%0d/%b required 15/0 both",
                     ch4(w_count, 2), w_ovf[2], ch4(s_count, 2), s_ovf[2]);
        end
        step(1);
        checks++;
        if (ch4(w_count, 2) !== 4'd0 || w_ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_edge ch2=%0d ovf=%b required ch2=0 ovf=1", ch4(w_count, 2), w_ovf[2]);
        end
        step(1);
        ev_i = 4'b0000;
        checks++;
        if (ch4(w_count, 2) !== 4'd1 || w_ovf[2] !== 1'b1 || w_ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end ch2=%0d ovf=%b required ch2=1 ovf[2]=1 ovf[1]=0",
                     ch4(w_count, 2), w_ovf);
        end
        checks++;
        if (ch4(s_count, 2) !== 4'd15 || s_ovf[2] !== 1'b1 || s_ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_end ch2=%0d ovf=%b required ch2=15 ovf[2]=1 ovf[1]=0",
                     ch4(s_count, 2), s_ovf);
        end
        checks++;
        if (ch32(m_count, 2) !== 32'd17 || m_ovf[2] !== 1'b0) begin
            failures++;
            $display("FAIL wide_ch2 got=%0d ovf=%b required 17 ovf=0", ch32(m_count, 2), m_ovf[2]);
        end
        step(3);
        checks++;
        if (w_ovf[2] !== 1'b1 || s_ovf[2] !== 1'b1 || ch4(w_count, 2) !== 4'd1) begin
            failures++;
            $display("FAIL ovf_sticky wrap_ovf=%b sat_ovf=%b wrap_ch2=%0d required 1 1 1",
                     w_ovf[2], s_ovf[2], ch4(w_count, 2));
        end
    endtask

    initial begin
        test_reset();
        test_autostart();
        test_stop_hold();
        test_snap_clear();
        test_all_controls();
        test_rst_midcount();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
